regfile_read_arbiter: RTL and testbench

Round-robin arbiter that shares one register-file read port among four requesters. Each cycle it picks one pending requester, drives the 4:1 read-select (`sel`) and the read address, captures the returned word, and hands it back with a per-requester valid pulse. It sits between the four read clients (decode, forwarding check, debug, store-data path) and the register file read mux tree. An optional lock lets one requester hold the port for a bounded burst.

---
 rtl/regfile_read_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_read_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among four
// requesters, with bounded lock bursts and a one-stage read-data pipeline.
//
// Ports:
//   clk, reset      : clock, async active-high reset
//   req[3:0]        : per-requester read request
//   lock[3:0]       : per-requester burst request (qualified by req)
//   addr            : packed read addresses, requester i at [i*AW +: AW]
//   gnt[3:0]        : registered one-hot grant
//   sel[1:0]        : binary index of the granted requester
//   rd_addr         : registered address to the register file
//   rd_data         : combinational read data for rd_addr
//   rdata           : captured read word
//   rvalid[3:0]     : one-hot pulse marking the owner of rdata
module regfile_read_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int BURST_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req,
  input  logic [3:0]              lock,
  input  logic [4*ADDR_WIDTH-1:0] addr,
  output logic [3:0]              gnt,
  output logic [1:0]              sel,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [3:0]              rvalid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] BCAP = 4'(BURST_MAX - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_gnt;
  logic [1:0]              r_sel;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [3:0]              r_rvalid;
  logic [1:0]              r_ptr;
  logic [3:0]              r_bcnt;
  logic                    r_locked;

  logic                    w_cont;
  logic                    w_rr_hit;
  logic [1:0]              w_rr_idx;
  logic [1:0]              w_idx;
  logic [1:0]              w_win;
  logic [3:0]              w_gnt_nxt;
  logic [3:0]              w_bcnt_nxt;
  logic                    w_locked_nxt;

  always_comb begin
    w_cont       = 1'b0;
    w_rr_hit     = 1'b0;
    w_rr_idx     = 2'd0;
    w_idx        = 2'd0;
    w_win        = 2'd0;
    w_gnt_nxt    = 4'b0000;
    w_bcnt_nxt   = 4'd0;
    w_locked_nxt = 1'b0;
    w_state_nxt  = IDLE;

    // Burst continues only if the owner won with lock and still holds it.
    w_cont = (r_state == GRANT) && r_locked &&
             req[r_sel] && lock[r_sel] &&
             (r_bcnt < BCAP);

    // Descending scan so the offset closest to ptr is written last.
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_idx;
      end
    end

    w_win = w_cont ? r_sel : w_rr_idx;

    if (|req) begin
      w_state_nxt  = GRANT;
      w_gnt_nxt    = 4'b0001 << w_win;
      w_bcnt_nxt   = w_cont ? r_bcnt + 4'd1 : 4'd0;
      w_locked_nxt = lock[w_win];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_rd_addr <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 4'b0000;
      r_ptr     <= 2'd0;
      r_bcnt    <= 4'd0;
      r_locked  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_locked <= w_locked_nxt;
      r_rdata  <= rd_data;
      r_rvalid <= r_gnt;
      if (w_state_nxt == GRANT) begin
        r_sel     <= w_win;
        r_ptr     <= w_win + 2'd1;
        r_rd_addr <= addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // w_rr_hit is implied by |req; kept for readability of the scan.
  logic w_unused;
  assign w_unused = w_rr_hit;

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign rd_addr = r_rd_addr;
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Testbench for regfile_read_arbiter: vector table plus hand sequences,
// with a queue carrying expected rvalid/rdata one cycle behind gnt.
module tb_regfile_read_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [3:0]    lock = 4'b0000;
  logic [4*AW-1:0] addr;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] rdata;
  logic [3:0]    rvalid;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] adr [4];
  logic [3:0]    q [$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
  } vec_t;

  vec_t tbl [25];

  regfile_read_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_MAX (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .lock   (lock),
    .addr   (addr),
    .gnt    (gnt),
    .sel    (sel),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rf(input logic [AW-1:0] a);
    if (a == 5'd7) return 64'hDEAD_BEEF;
    return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h1_0001);
  endfunction

  assign rd_data = rf(rd_addr);
  assign addr = {adr[3], adr[2], adr[1], adr[0]};

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input logic [3:0] eg, input string nm);
    logic [3:0] erv;
    logic [1:0] ei;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
      erv = 4'b0000;
    end else begin
      erv = q.pop_front();
    end
    chk({nm, " rvalid"}, DW'(rvalid), DW'(erv));
    if (erv != 4'b0000)
      chk({nm, " rdata"}, rdata, rf(adr[idx_of(erv)]));
    chk({nm, " gnt"}, DW'(gnt), DW'(eg));
    if (eg != 4'b0000) begin
      ei = idx_of(eg);
      chk({nm, " sel"}, DW'(sel), DW'(ei));
      chk({nm, " rd_addr"}, DW'(rd_addr), DW'(adr[ei]));
    end
    q.push_back(eg);
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] lk,
                      input logic [3:0] eg, input string nm);
    req  = rq;
    lock = lk;
    @(posedge clk);
    @(negedge clk);
    check_out(eg, nm);
  endtask

  // Entered at a negedge; reset is checked before the next clock edge.
  task automatic do_reset(input logic [3:0] rq_after);
    reset = 1'b1;
    #1;
    chk("rst gnt", DW'(gnt), '0);
    chk("rst sel", DW'(sel), '0);
    chk("rst rd_addr", DW'(rd_addr), '0);
    chk("rst rdata", rdata, '0);
    chk("rst rvalid", DW'(rvalid), '0);
    q.delete();
    q.push_back(4'b0000);
    req  = rq_after;
    lock = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    adr[0] = 5'd3;
    adr[1] = 5'd12;
    adr[2] = 5'd7;
    adr[3] = 5'd20;

    // Round robin from ptr=0
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000};
    // Single read of requester 2 (addr 7)
    tbl[9]  = '{4'b0100, 4'b0000, 4'b0100};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000};
    // Wrap: 3 then 0
    tbl[11] = '{4'b1000, 4'b0000, 4'b1000};
    tbl[12] = '{4'b1001, 4'b0000, 4'b0001};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000};
    // Lock without req has no effect
    tbl[15] = '{4'b0010, 4'b1101, 4'b0010};
    tbl[16] = '{4'b0011, 4'b0000, 4'b0001};
    tbl[17] = '{4'b0011, 4'b0000, 4'b0010};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000};
    // Lone locked requester keeps winning past the cap
    tbl[19] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[20] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[21] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[22] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[23] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[24] = '{4'b0001, 4'b0001, 4'b0001};

    @(negedge clk);
    do_reset(4'b0000);

    for (int i = 0; i < 25; i++)
      step(tbl[i].req, tbl[i].lock, tbl[i].gnt, $sformatf("vec%0d", i));
    step(4'b0000, 4'b0000, 4'b0000, "drain0");

    // Mid-burst reset, then requester 0 favoured
    step(4'b0100, 4'b0100, 4'b0100, "mb0");
    step(4'b0100, 4'b0100, 4'b0100, "mb1");
    do_reset(4'b1111);
    step(4'b1111, 4'b0000, 4'b0001, "post_rst");
    step(4'b0000, 4'b0000, 4'b0000, "post_rst_idle");

    // Locked burst with BURST_MAX=4
    @(negedge clk);
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++)
      step(4'b0011, 4'b0001, 4'b0001, $sformatf("burstA%0d", i));
    step(4'b0011, 4'b0001, 4'b0010, "burst_other");
    for (int i = 0; i < 4; i++)
      step(4'b0011, 4'b0001, 4'b0001, $sformatf("burstB%0d", i));
    step(4'b0000, 4'b0000, 4'b0000, "burst_end0");
    step(4'b0000, 4'b0000, 4'b0000, "burst_end1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
